// File: rtl/bus_initiator.sv
// Register-bus initiator: turns one request into one or two byte cycles with
// programmable setup / strobe / hold timing and returns a completion pulse.
module bus_initiator #(
  parameter int unsigned SETUP_CYCLES  = 2,
  parameter int unsigned STROBE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES   = 2
) (
  input  logic        clk,
  input  logic        reset_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_rd_nwr_i,
  input  logic [3:0]  req_reg_num_i,
  input  logic        req_word_i,
  input  logic        req_bytesel_i,
  input  logic [15:0] req_data_i,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_data_o,
  output logic        bus_cs_n_o,
  output logic        bus_rd_nwr_o,
  output logic [3:0]  bus_reg_num_o,
  output logic        bus_bytesel_o,
  output logic [7:0]  bus_data_o,
  output logic        bus_data_oe_o,
  input  logic [7:0]  bus_data_i
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYCLES - 1);

  state_t      state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic        rd_r, word_r, phase_r;
  logic [7:0]  odd_byte_r;
  logic [15:0] cap_r;
  logic        accept_s, last_strobe_s;

  function automatic logic [7:0] lane_byte(input logic [15:0] d, input logic odd);
    return odd ? d[7:0] : d[15:8];
  endfunction

  assign req_ready_o = (state_r == IDLE) && reset_n_i;
  assign accept_s    = req_valid_i && req_ready_o;

  // Next-state and phase-counter logic; the counter reloads on every state change.
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    last_strobe_s = (state_r == STROBE) && (cnt_r == 4'd0);
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = SETUP;
          cnt_s   = SETUP_LOAD;
        end else begin
          state_s = IDLE;
          cnt_s   = cnt_r;
        end
      end
      SETUP: begin
        if (cnt_r == 4'd0) begin
          state_s = STROBE;
          cnt_s   = STROBE_LOAD;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      STROBE: begin
        if (cnt_r == 4'd0) begin
          state_s = HOLD;
          cnt_s   = HOLD_LOAD;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      HOLD: begin
        if (cnt_r == 4'd0) begin
          if (word_r && !phase_r) begin
            state_s = SETUP;
            cnt_s   = SETUP_LOAD;
          end else begin
            state_s = DONE;
            cnt_s   = 4'd0;
          end
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      DONE: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // State, request capture and registered bus/response outputs.
  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      state_r       <= IDLE;
      cnt_r         <= 4'd0;
      rd_r          <= 1'b1;
      word_r        <= 1'b0;
      phase_r       <= 1'b0;
      odd_byte_r    <= 8'h00;
      cap_r         <= 16'h0000;
      rsp_valid_o   <= 1'b0;
      rsp_data_o    <= 16'h0000;
      bus_cs_n_o    <= 1'b1;
      bus_rd_nwr_o  <= 1'b1;
      bus_reg_num_o <= 4'd0;
      bus_bytesel_o <= 1'b0;
      bus_data_o    <= 8'h00;
      bus_data_oe_o <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      rsp_valid_o <= (state_s == DONE);
      bus_cs_n_o  <= (state_s != STROBE);

      if (accept_s) begin
        rd_r          <= req_rd_nwr_i;
        word_r        <= req_word_i;
        phase_r       <= 1'b0;
        odd_byte_r    <= req_data_i[7:0];
        bus_reg_num_o <= req_reg_num_i;
        bus_bytesel_o <= req_word_i ? 1'b0 : req_bytesel_i;
        bus_data_o    <= lane_byte(req_data_i, req_word_i ? 1'b0 : req_bytesel_i);
      end else if ((state_r == HOLD) && (state_s == SETUP)) begin
        phase_r       <= 1'b1;
        bus_bytesel_o <= 1'b1;
        bus_data_o    <= odd_byte_r;
      end else begin
        phase_r <= phase_r;
      end

      if ((state_s == IDLE) || (state_s == DONE)) begin
        bus_rd_nwr_o  <= 1'b1;
        bus_data_oe_o <= 1'b0;
      end else if (accept_s) begin
        bus_rd_nwr_o  <= req_rd_nwr_i;
        bus_data_oe_o <= !req_rd_nwr_i;
      end else begin
        bus_rd_nwr_o  <= bus_rd_nwr_o;
      end

      // Even byte lands in the high half; a lone byte is right-aligned.
      if (last_strobe_s && rd_r) begin
        if (!word_r) begin
          cap_r <= {8'h00, bus_data_i};
        end else if (!phase_r) begin
          cap_r[15:8] <= bus_data_i;
        end else begin
          cap_r[7:0] <= bus_data_i;
        end
      end else begin
        cap_r <= cap_r;
      end

      if ((state_s == DONE) && rd_r) begin
        rsp_data_o <= cap_r;
      end else begin
        rsp_data_o <= rsp_data_o;
      end
    end
  end

endmodule

// File: tb/tb_bus_initiator.sv
// Self-checking bench for bus_initiator: directed and random transactions
// compared cycle by cycle against a timeline model derived from the timing rules.
module tb_bus_initiator;

  localparam int S = 2;
  localparam int T = 4;
  localparam int H = 2;

  logic        clk = 1'b0;
  logic        reset_n_i;
  logic        req_valid_i, req_rd_nwr_i, req_word_i, req_bytesel_i;
  logic [3:0]  req_reg_num_i;
  logic [15:0] req_data_i;
  logic        req_ready_o, rsp_valid_o;
  logic [15:0] rsp_data_o;
  logic        bus_cs_n_o, bus_rd_nwr_o, bus_bytesel_o, bus_data_oe_o;
  logic [3:0]  bus_reg_num_o;
  logic [7:0]  bus_data_o, bus_data_i;

  logic        r2_valid, r2_ready, r2_rsp_valid, r2_cs_n, r2_rd_nwr, r2_bytesel, r2_oe;
  logic [15:0] r2_rsp_data;
  logic [3:0]  r2_reg;
  logic [7:0]  r2_data_o, r2_data_i;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] last_rsp;

  always #5 clk = ~clk;

  bus_initiator #(.SETUP_CYCLES(S), .STROBE_CYCLES(T), .HOLD_CYCLES(H)) dut (
    .clk(clk), .reset_n_i(reset_n_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_rd_nwr_i(req_rd_nwr_i),
    .req_reg_num_i(req_reg_num_i), .req_word_i(req_word_i), .req_bytesel_i(req_bytesel_i),
    .req_data_i(req_data_i), .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
    .bus_cs_n_o(bus_cs_n_o), .bus_rd_nwr_o(bus_rd_nwr_o), .bus_reg_num_o(bus_reg_num_o),
    .bus_bytesel_o(bus_bytesel_o), .bus_data_o(bus_data_o), .bus_data_oe_o(bus_data_oe_o),
    .bus_data_i(bus_data_i)
  );

  bus_initiator #(.SETUP_CYCLES(1), .STROBE_CYCLES(1), .HOLD_CYCLES(1)) dut2 (
    .clk(clk), .reset_n_i(reset_n_i),
    .req_valid_i(r2_valid), .req_ready_o(r2_ready), .req_rd_nwr_i(1'b0),
    .req_reg_num_i(4'd6), .req_word_i(1'b0), .req_bytesel_i(1'b1),
    .req_data_i(16'hBEEF), .rsp_valid_o(r2_rsp_valid), .rsp_data_o(r2_rsp_data),
    .bus_cs_n_o(r2_cs_n), .bus_rd_nwr_o(r2_rd_nwr), .bus_reg_num_o(r2_reg),
    .bus_bytesel_o(r2_bytesel), .bus_data_o(r2_data_o), .bus_data_oe_o(r2_oe),
    .bus_data_i(r2_data_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s failed", tag);
    end
  endtask

  // One transaction accepted in the current (IDLE) cycle; returns at the next IDLE cycle.
  task automatic run_txn(input logic rd, input logic [3:0] rg, input logic word,
                         input logic bsel, input logic [15:0] wd,
                         input logic [7:0] b0, input logic [7:0] b1);
    int per, len, p, o;
    logic lane, lane_last;
    logic [7:0] eb;
    logic [15:0] exp_rsp;
    per       = S + T + H;
    len       = word ? 2 * per + 1 : per + 1;
    exp_rsp   = rd ? (word ? {b0, b1} : {8'h00, b0}) : last_rsp;
    lane_last = word ? 1'b1 : bsel;
    chk("ready_idle", {31'd0, req_ready_o}, 32'd1);
    req_valid_i   = 1'b1;
    req_rd_nwr_i  = rd;
    req_reg_num_i = rg;
    req_word_i    = word;
    req_bytesel_i = bsel;
    req_data_i    = wd;
    bus_data_i    = 8'($urandom);
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      p    = (k - 1) / per;
      o    = (k - 1) % per;
      lane = (k < len) ? (word ? p[0] : bsel) : lane_last;
      eb   = lane ? wd[7:0] : wd[15:8];
      chk("ready_busy", {31'd0, req_ready_o}, 32'd0);
      chk("reg_num", {28'd0, bus_reg_num_o}, {28'd0, rg});
      chk("bytesel", {31'd0, bus_bytesel_o}, {31'd0, lane});
      chk("data_o", {24'd0, bus_data_o}, {24'd0, eb});
      if (k < len) begin
        chk("cs_n", {31'd0, bus_cs_n_o}, {31'd0, !((o >= S) && (o < S + T))});
        chk("rd_nwr", {31'd0, bus_rd_nwr_o}, {31'd0, rd});
        chk("oe", {31'd0, bus_data_oe_o}, {31'd0, !rd});
        chk("rsp_valid_lo", {31'd0, rsp_valid_o}, 32'd0);
      end else begin
        chk("cs_n_done", {31'd0, bus_cs_n_o}, 32'd1);
        chk("rd_nwr_done", {31'd0, bus_rd_nwr_o}, 32'd1);
        chk("oe_done", {31'd0, bus_data_oe_o}, 32'd0);
        chk("rsp_valid_hi", {31'd0, rsp_valid_o}, 32'd1);
        chk("rsp_data", {16'd0, rsp_data_o}, {16'd0, exp_rsp});
      end
      // Junk on req_* while busy must be ignored; real byte only on the last strobe cycle.
      req_valid_i   = (k < len) ? 1'($urandom) : 1'b0;
      req_rd_nwr_i  = 1'($urandom);
      req_reg_num_i = 4'($urandom);
      req_word_i    = 1'($urandom);
      req_bytesel_i = 1'($urandom);
      req_data_i    = 16'($urandom);
      bus_data_i    = ((k < len) && (o == S + T - 1)) ? (p[0] ? b1 : b0) : 8'($urandom);
    end
    @(negedge clk);
    chk("ready_after", {31'd0, req_ready_o}, 32'd1);
    chk("rsp_valid_after", {31'd0, rsp_valid_o}, 32'd0);
    chk("cs_n_after", {31'd0, bus_cs_n_o}, 32'd1);
    last_rsp = exp_rsp;
  endtask

  initial begin
    reset_n_i     = 1'b0;
    req_valid_i   = 1'b0;
    req_rd_nwr_i  = 1'b0;
    req_reg_num_i = 4'd0;
    req_word_i    = 1'b0;
    req_bytesel_i = 1'b0;
    req_data_i    = 16'h0000;
    bus_data_i    = 8'h00;
    r2_valid      = 1'b0;
    r2_data_i     = 8'h00;
    last_rsp      = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", {31'd0, bus_cs_n_o}, 32'd1);
    chk("rst_rd_nwr", {31'd0, bus_rd_nwr_o}, 32'd1);
    chk("rst_oe", {31'd0, bus_data_oe_o}, 32'd0);
    chk("rst_reg", {28'd0, bus_reg_num_o}, 32'd0);
    chk("rst_bytesel", {31'd0, bus_bytesel_o}, 32'd0);
    chk("rst_data", {24'd0, bus_data_o}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("rst_rsp_data", {16'd0, rsp_data_o}, 32'd0);
    chk("rst_ready", {31'd0, req_ready_o}, 32'd0);
    reset_n_i = 1'b1;
    @(negedge clk);

    run_txn(1'b0, 4'd3, 1'b1, 1'b0, 16'hA55A, 8'h00, 8'h00);
    run_txn(1'b1, 4'd9, 1'b1, 1'b0, 16'h0000, 8'h12, 8'h34);
    run_txn(1'b1, 4'd2, 1'b0, 1'b1, 16'h0000, 8'hFF, 8'h00);
    run_txn(1'b0, 4'd4, 1'b0, 1'b0, 16'h1357, 8'h00, 8'h00);
    run_txn(1'b0, 4'd5, 1'b0, 1'b1, 16'h2468, 8'h00, 8'h00);
    for (int n = 0; n < 24; n++) begin
      run_txn(1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
              16'($urandom), 8'($urandom), 8'($urandom));
    end

    // Abort a byte write in the middle of its strobe.
    req_valid_i   = 1'b1;
    req_rd_nwr_i  = 1'b0;
    req_reg_num_i = 4'd5;
    req_word_i    = 1'b0;
    req_bytesel_i = 1'b0;
    req_data_i    = 16'h77EE;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      req_valid_i = 1'b0;
    end
    chk("pre_rst_cs_n", {31'd0, bus_cs_n_o}, 32'd0);
    chk("pre_rst_oe", {31'd0, bus_data_oe_o}, 32'd1);
    reset_n_i = 1'b0;
    @(negedge clk);
    chk("abort_cs_n", {31'd0, bus_cs_n_o}, 32'd1);
    chk("abort_oe", {31'd0, bus_data_oe_o}, 32'd0);
    chk("abort_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("abort_rsp_data", {16'd0, rsp_data_o}, 32'd0);
    chk("abort_reg", {28'd0, bus_reg_num_o}, 32'd0);
    reset_n_i = 1'b1;
    #1;
    chk("abort_ready", {31'd0, req_ready_o}, 32'd1);
    last_rsp = 16'h0000;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("abort_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
      chk("abort_idle_cs", {31'd0, bus_cs_n_o}, 32'd1);
    end
    run_txn(1'b1, 4'd1, 1'b0, 1'b0, 16'h0000, 8'hC3, 8'h00);

    // Minimum timing instance: strobe only in cycle 2, completion in cycle 4.
    chk("min_ready", {31'd0, r2_ready}, 32'd1);
    r2_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      r2_valid = 1'b0;
      chk("min_cs_n", {31'd0, r2_cs_n}, {31'd0, k != 2});
      chk("min_rsp_valid", {31'd0, r2_rsp_valid}, {31'd0, k == 4});
      if (k < 4) begin
        chk("min_oe", {31'd0, r2_oe}, 32'd1);
        chk("min_data", {24'd0, r2_data_o}, 32'hEF);
      end else begin
        chk("min_oe_idle", {31'd0, r2_oe}, 32'd0);
      end
    end
    chk("min_ready_end", {31'd0, r2_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_initiator.md
BUS_INITIATOR -- requirements
Module: bus_initiator

Interface
REQ-001 Parameter: SETUP_CYCLES, default 2, cycles address/control/data are stable before bus_cs_n_o falls (legal 1..15).
REQ-002 Parameter: STROBE_CYCLES, default 4, cycles bus_cs_n_o is held low per byte (legal 1..15).
REQ-003 Parameter: HOLD_CYCLES, default 2, cycles address/control/data stay stable after bus_cs_n_o rises (legal 1..15).
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 reset_n_i  input  1  reset, synchronous, active-low.
REQ-006 req_valid_i  input  1  request offered.
REQ-007 req_ready_o  output  1  request accepted when req_valid_i and req_ready_o are both high.
REQ-008 req_rd_nwr_i  input  1  request direction: 1 = read, 0 = write.
REQ-009 req_reg_num_i  input  4  target register number.
REQ-010 req_word_i  input  1  1 = two byte cycles (even, then odd); 0 = one byte cycle.
REQ-011 req_bytesel_i  input  1  byte lane for a single-byte request; ignored when req_word_i=1.
REQ-012 req_data_i  input  16  write data: [15:8] even byte, [7:0] odd byte; a single-byte write uses the lane matching req_bytesel_i.
REQ-013 rsp_valid_o  output  1  one-cycle completion pulse, issued for both reads and writes.
REQ-014 rsp_data_o  output  16  read result, valid while rsp_valid_o is high.
REQ-015 bus_cs_n_o  output  1  register select strobe, active-low.
REQ-016 bus_rd_nwr_o  output  1  1 = read, 0 = write.
REQ-017 bus_reg_num_o  output  4  register number.
REQ-018 bus_bytesel_o  output  1  0 = even byte, 1 = odd byte.
REQ-019 bus_data_o  output  8  write data byte.
REQ-020 bus_data_oe_o  output  1  data bus drive enable.
REQ-021 bus_data_i  input  8  read data byte from the bus.

Function
REQ-022 The block SHALL implement a state machine with states IDLE, SETUP, STROBE, HOLD and DONE; req_ready_o SHALL be high only in IDLE while reset_n_i=1.
REQ-023 On acceptance, the block SHALL register the direction, register number, word/byte mode, byte lane and data, then enter SETUP on the next cycle; req_* inputs SHALL be ignored outside IDLE.
REQ-024 SETUP, STROBE and HOLD SHALL each last exactly SETUP_CYCLES, STROBE_CYCLES and HOLD_CYCLES cycles, timed by one down-counter that reloads on every state change.
REQ-025 bus_cs_n_o SHALL be 0 only in STROBE; bus_reg_num_o, bus_rd_nwr_o, bus_bytesel_o and bus_data_o SHALL remain constant through SETUP, STROBE and HOLD of each byte.
REQ-026 bus_data_oe_o SHALL be 1 only in SETUP, STROBE and HOLD of write requests; it SHALL never be 1 during a read.
REQ-027 Read capture: bus_data_i SHALL be sampled in the last STROBE cycle; even byte to rsp_data_o[15:8], odd byte to rsp_data_o[7:0].
REQ-028 A single-byte read SHALL return the captured byte in rsp_data_o[7:0] with [15:8]=0, whichever lane was read.
REQ-029 Writes SHALL leave rsp_data_o unchanged.
REQ-030 For a word request, the end of the even-byte HOLD SHALL go directly to SETUP of the odd byte (bus_bytesel_o=1); bus_cs_n_o therefore stays high for HOLD_CYCLES+SETUP_CYCLES cycles between the two strobes.
REQ-031 The end of the last HOLD SHALL enter DONE for exactly one cycle, with rsp_valid_o=1 and req_ready_o=0, then return to IDLE.
REQ-032 Latency from the acceptance cycle (cycle 0): DONE occurs at cycle S+T+H+1 for a byte request and at cycle 2(S+T+H)+1 for a word request.
REQ-033 In IDLE and DONE, bus outputs SHALL be at their idle values: bus_cs_n_o=1, bus_rd_nwr_o=1, bus_data_oe_o=0; bus_reg_num_o, bus_bytesel_o and bus_data_o hold their last values.

Reset
REQ-034 While reset_n_i=0 at a clock edge, from the next cycle onward: state=IDLE, bus_cs_n_o=1, bus_rd_nwr_o=1, bus_data_oe_o=0, bus_reg_num_o=0, bus_bytesel_o=0, bus_data_o=0, rsp_valid_o=0, rsp_data_o=0, counter=0.
REQ-035 A reset during any state SHALL abort the transaction without a rsp_valid_o pulse; req_ready_o SHALL be 1 in the first cycle after reset_n_i returns to 1.

Verification (S=2, T=4, H=2 unless stated; acceptance at cycle 0)
REQ-036 Word write, reg 3, data 0xA55A -> cs_n low cycles 3-6 (bytesel 0, data 0xA5, oe 1) and cycles 11-14 (bytesel 1, data 0x5A); rsp_valid_o at cycle 17 only.
REQ-037 Word read, reg 9, bus model drives 0x12 then 0x34 during the strobes -> rsp_data_o=0x1234 at cycle 17; oe stays 0 throughout.
REQ-038 Byte read, bytesel 1, bus drives 0xFF -> rsp_data_o=0x00FF with rsp_valid_o at cycle 9.
REQ-039 req_valid_i held high with two byte writes queued -> second accepted at cycle 10; cs_n gap between strobes is at least 4 cycles.
REQ-040 reset_n_i=0 for one cycle during STROBE of a write -> next cycle cs_n=1, oe=0; no rsp_valid_o; ready=1 after release.
REQ-041 S=T=H=1, byte write -> cs_n low only at cycle 2; rsp_valid_o at cycle 4.
